// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer: bus map, register
// bit positions and the run-sequencing state encoding.
package matmul_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_CYCLES = 8'h08;
  localparam logic [7:0] ADDR_A_BASE = 8'h10;
  localparam logic [7:0] ADDR_B_BASE = 8'h20;
  localparam logic [7:0] ADDR_C_BASE = 8'h40;

  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_DONE_CLR = 2;
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;

  localparam int STEP_W  = 8;
  localparam int DRAIN_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int word_of(input logic [7:0] addr);
    return int'(addr[7:2]);
  endfunction

endpackage

// File: rtl/matmul_skew_feeder.sv
// Combinational operand skew: lane l carries element (step - l) of its
// row/column while that index is inside the matrix, zero otherwise.
module matmul_skew_feeder
  import matmul_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8
) (
  input  logic                       active,
  input  logic [STEP_W-1:0]          step,
  input  logic [N*N*DATA_W-1:0]      a_ops,
  input  logic [N*N*DATA_W-1:0]      b_ops,
  output logic [N*DATA_W-1:0]        lane_a,
  output logic [N*DATA_W-1:0]        lane_b
);

  always_comb begin
    lane_a = '0;
    lane_b = '0;
    if (active) begin
      for (int l = 0; l < N; l++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(step) == l + k) begin
            lane_a[l*DATA_W +: DATA_W] = a_ops[(l*N+k)*DATA_W +: DATA_W];
            lane_b[l*DATA_W +: DATA_W] = b_ops[(l*N+k)*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Bus-mapped sequencer for an output-stationary NxN systolic multiply array:
// operand registers, run FSM, cycle counter and level interrupt.
//
// state | meaning
// IDLE  | waiting for START, operands writable
// CLEAR | one cycle of accumulator clear
// FEED  | 3N-2 cycles of skewed operands, step t counts up
// DRAIN | SA_LAT cycles of zero operands to flush the array pipeline
// DONE  | one cycle: latch CYCLES, set DONE
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SA_LAT = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   bus_sel_i,
  input  logic                   bus_we_i,
  input  logic [7:0]             bus_addr_i,
  input  logic [31:0]            bus_wdata_i,
  output logic [31:0]            bus_rdata_o,
  output logic                   bus_ready_o,
  output logic                   sa_clr_o,
  output logic                   sa_en_o,
  output logic [N*DATA_W-1:0]    sa_a_o,
  output logic [N*DATA_W-1:0]    sa_b_o,
  input  logic [N*N*ACC_W-1:0]   sa_c_i,
  output logic                   irq_o
);

  localparam int OPW = N * DATA_W;
  localparam logic [STEP_W-1:0]  FEED_LAST  = STEP_W'(3*N-3);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'((SA_LAT > 0) ? SA_LAT - 1 : 0);

  state_t               state_q, state_nx;
  logic [STEP_W-1:0]    step_q;
  logic [DRAIN_W-1:0]   drain_q;
  logic [31:0]          run_cnt_q, cycles_q, rdata_q, rd_mux;
  logic                 done_q, irq_en_q, irq_q, ready_q;
  logic [OPW-1:0]       a_row_q [N];
  logic [OPW-1:0]       b_col_q [N];
  logic [N*OPW-1:0]     a_flat, b_flat;
  logic                 accept, aligned, wr, rd, busy, ctrl_wr, start_go;
  int                   widx;

  assign accept   = bus_sel_i & ~ready_q;
  assign aligned  = (bus_addr_i[1:0] == 2'b00);
  assign widx     = int'(bus_addr_i[7:2]);
  assign wr       = accept & bus_we_i & aligned;
  assign rd       = accept & ~bus_we_i;
  assign busy     = (state_q != ST_IDLE);
  assign ctrl_wr  = wr && (widx == word_of(ADDR_CTRL));
  assign start_go = ctrl_wr && bus_wdata_i[CTRL_START] && !busy;

  always_comb begin
    a_flat = '0;
    b_flat = '0;
    for (int r = 0; r < N; r++) begin
      a_flat[r*OPW +: OPW] = a_row_q[r];
      b_flat[r*OPW +: OPW] = b_col_q[r];
    end
  end

  matmul_skew_feeder #(
    .N      (N),
    .DATA_W (DATA_W)
  ) u_feeder (
    .active (state_q == ST_FEED),
    .step   (step_q),
    .a_ops  (a_flat),
    .b_ops  (b_flat),
    .lane_a (sa_a_o),
    .lane_b (sa_b_o)
  );

  always_comb begin
    state_nx = state_q;
    sa_clr_o = 1'b0;
    sa_en_o  = 1'b0;
    case (state_q)
      ST_IDLE:  if (start_go) state_nx = ST_CLEAR;
      ST_CLEAR: begin
        sa_clr_o = 1'b1;
        state_nx = ST_FEED;
      end
      ST_FEED: begin
        sa_en_o = 1'b1;
        if (step_q == FEED_LAST) state_nx = (SA_LAT > 0) ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN: begin
        sa_en_o = 1'b1;
        if (drain_q == '0) state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    if (aligned) begin
      if (widx == word_of(ADDR_CTRL)) rd_mux[CTRL_IRQ_EN] = irq_en_q;
      if (widx == word_of(ADDR_STATUS)) begin
        rd_mux[STAT_BUSY] = busy;
        rd_mux[STAT_DONE] = done_q;
      end
      if (widx == word_of(ADDR_CYCLES)) rd_mux = cycles_q;
      for (int r = 0; r < N; r++) begin
        if (widx == word_of(ADDR_A_BASE) + r) rd_mux = 32'(a_row_q[r]);
        if (widx == word_of(ADDR_B_BASE) + r) rd_mux = 32'(b_col_q[r]);
      end
      // Results come straight from the array, live even mid-run.
      for (int e = 0; e < N*N; e++) begin
        if (widx == word_of(ADDR_C_BASE) + e) rd_mux = 32'(sa_c_i[e*ACC_W +: ACC_W]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      drain_q   <= '0;
      run_cnt_q <= '0;
      cycles_q  <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      ready_q   <= 1'b0;
      for (int r = 0; r < N; r++) begin
        a_row_q[r] <= '0;
        b_col_q[r] <= '0;
      end
    end else begin
      state_q <= state_nx;
      ready_q <= accept;
      if (rd)          rdata_q <= rd_mux;
      else if (accept) rdata_q <= '0;

      if (state_q == ST_FEED) step_q <= step_q + 1'b1;
      else                    step_q <= '0;

      if (state_q == ST_FEED)                          drain_q <= DRAIN_INIT;
      else if (state_q == ST_DRAIN && drain_q != '0)   drain_q <= drain_q - 1'b1;

      if (start_go)  run_cnt_q <= '0;
      else if (busy) run_cnt_q <= run_cnt_q + 32'd1;

      if (start_go)                   cycles_q <= '0;
      else if (state_q == ST_DONE)    cycles_q <= run_cnt_q + 32'd1;

      // Completion wins over a coincident DONE_CLR so a finished run is never lost.
      if (state_q == ST_DONE)                              done_q <= 1'b1;
      else if (start_go || (ctrl_wr && bus_wdata_i[CTRL_DONE_CLR])) done_q <= 1'b0;

      if (ctrl_wr) irq_en_q <= bus_wdata_i[CTRL_IRQ_EN];
      irq_q <= done_q & irq_en_q;

      for (int r = 0; r < N; r++) begin
        if (wr && !busy && widx == word_of(ADDR_A_BASE) + r) a_row_q[r] <= bus_wdata_i[OPW-1:0];
        if (wr && !busy && widx == word_of(ADDR_B_BASE) + r) b_col_q[r] <= bus_wdata_i[OPW-1:0];
      end
    end
  end

  assign bus_rdata_o = rdata_q;
  assign bus_ready_o = ready_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: behavioural 4x4 output-stationary array driven by
// the DUT, matrix-product reference, and a read-data scoreboard.
module tb_matmul_seq_ctrl;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               bus_sel, bus_we;
  logic [7:0]         bus_addr;
  logic [31:0]        bus_wdata;
  logic [31:0]        bus_rdata_o;
  logic               bus_ready_o, sa_clr_o, sa_en_o, irq_o;
  logic [N*DW-1:0]    sa_a_o, sa_b_o;
  logic [N*N*AW-1:0]  sa_c;

  always #5 clk = ~clk;

  matmul_seq_ctrl #(.N(N), .DATA_W(DW), .ACC_W(AW), .SA_LAT(1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus_sel_i   (bus_sel),
    .bus_we_i    (bus_we),
    .bus_addr_i  (bus_addr),
    .bus_wdata_i (bus_wdata),
    .bus_rdata_o (bus_rdata_o),
    .bus_ready_o (bus_ready_o),
    .sa_clr_o    (sa_clr_o),
    .sa_en_o     (sa_en_o),
    .sa_a_o      (sa_a_o),
    .sa_b_o      (sa_b_o),
    .sa_c_i      (sa_c),
    .irq_o       (irq_o)
  );

  // ---------------- behavioural systolic array ----------------
  logic signed [DW-1:0] ap  [N][N] = '{default: '0};
  logic signed [DW-1:0] bp  [N][N] = '{default: '0};
  logic signed [AW-1:0] acc [N][N] = '{default: '0};
  int clr_cnt = 0;

  always @(negedge clk) begin
    logic signed [DW-1:0] an [N][N];
    logic signed [DW-1:0] bn [N][N];
    if (sa_clr_o === 1'b1) begin
      clr_cnt++;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] = '0;
          ap[i][j]  = '0;
          bp[i][j]  = '0;
        end
    end else if (sa_en_o === 1'b1) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (j == 0) an[i][j] = sa_a_o[i*DW +: DW];
          else        an[i][j] = ap[i][j-1];
          if (i == 0) bn[i][j] = sa_b_o[j*DW +: DW];
          else        bn[i][j] = bp[i-1][j];
          acc[i][j] = acc[i][j] + an[i][j] * bn[i][j];
        end
      ap = an;
      bp = bn;
    end
  end

  for (genvar g = 0; g < N*N; g++) begin : g_c
    assign sa_c[g*AW +: AW] = acc[g/N][g%N];
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb_q[$];

  always @(negedge clk) begin
    sb_t e;
    if (bus_ready_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_ready: got ready=1 expected no pending access");
      end else begin
        e = sb_q.pop_front();
        if (e.chk) check(e.name, bus_rdata_o, e.exp);
      end
    end
  end

  // ---------------- reference ----------------
  int am [N][N];
  int bm [N][N];

  function automatic logic [31:0] ref_c(input int i, input int j);
    int s = 0;
    for (int k = 0; k < N; k++) s += am[i][k] * bm[k][j];
    return 32'(s);
  endfunction

  function automatic logic [31:0] row_word(input int i);
    logic [31:0] w = '0;
    for (int k = 0; k < N; k++) w[k*DW +: DW] = 8'(am[i][k]);
    return w;
  endfunction

  function automatic logic [31:0] col_word(input int j);
    logic [31:0] w = '0;
    for (int k = 0; k < N; k++) w[k*DW +: DW] = 8'(bm[k][j]);
    return w;
  endfunction

  // Edge lanes expected at feed step t: row i meets element t-i.
  function automatic logic [31:0] lanes_a(input int t);
    logic [31:0] w = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) w[i*DW +: DW] = 8'(am[i][t-i]);
    return w;
  endfunction

  function automatic logic [31:0] lanes_b(input int t);
    logic [31:0] w = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) w[j*DW +: DW] = 8'(bm[t-j][j]);
    return w;
  endfunction

  function automatic int rnd8();
    int v = int'($urandom_range(0, 255));
    return (v > 127) ? v - 256 : v;
  endfunction

  task automatic rand_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        am[i][j] = rnd8();
        bm[i][j] = rnd8();
      end
  endtask

  // ---------------- bus ----------------
  task automatic issue(input bit we, input logic [7:0] addr, input logic [31:0] wd,
                       input bit chk, input logic [31:0] exp, input string name,
                       output logic [31:0] rdv);
    sb_t e;
    @(posedge clk); #1;
    bus_sel   = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wd;
    e.chk = chk; e.exp = exp; e.name = name;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus_sel = 1'b0;
    bus_we  = 1'b0;
    rdv     = bus_rdata_o;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] wd);
    logic [31:0] d;
    issue(1'b1, addr, wd, 1'b0, '0, "wr", d);
  endtask

  task automatic rd_chk(input logic [7:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] d;
    issue(1'b0, addr, '0, 1'b1, exp, name, d);
  endtask

  task automatic load_mats();
    for (int i = 0; i < N; i++) wr(8'(8'h10 + 4*i), row_word(i));
    for (int j = 0; j < N; j++) wr(8'(8'h20 + 4*j), col_word(j));
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    bit ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      issue(1'b0, 8'h04, '0, 1'b0, '0, "poll", s);
      if (s[1] && !s[0]) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no DONE expected DONE within 40 polls", tag);
    end
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        rd_chk(8'(8'h40 + 4*(i*N+j)), ref_c(i, j), $sformatf("%s_C%0d%0d", tag, i, j));
    rd_chk(8'h08, 32'd13, {tag, "_cycles"});
  endtask

  task automatic run(input string tag);
    load_mats();
    wr(8'h00, 32'h1);
    wait_done(tag);
    check_results(tag);
  endtask

  // Cycle-exact run: start accepted at edge 0, DONE state in cycle 13.
  task automatic timed_run(input bit ien, input string tag);
    logic [31:0] d;
    issue(1'b1, 8'h00, ien ? 32'h3 : 32'h1, 1'b0, '0, "start", d);
    check({tag, "_clr"}, 32'(sa_clr_o), 32'd1);
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        check({tag, "_a_t0"}, sa_a_o, lanes_a(0));
        check({tag, "_b_t0"}, sa_b_o, lanes_b(0));
      end
      if (c == 5) begin
        check({tag, "_a_t4"}, sa_a_o, lanes_a(4));
        check({tag, "_b_t4"}, sa_b_o, lanes_b(4));
      end
      if (c == 11) check({tag, "_en_drain"}, 32'(sa_en_o), 32'd1);
      if (c == 12) check({tag, "_en_done"}, 32'(sa_en_o), 32'd0);
      if (c == 13) check({tag, "_irq_early"}, 32'(irq_o), 32'd0);
      if (c == 14) check({tag, "_irq"}, 32'(irq_o), 32'(ien));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] row0_saved;
    int clr_before;

    rst = 1'b1; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clr",   32'(sa_clr_o),    32'd0);
    check("rst_en",    32'(sa_en_o),     32'd0);
    check("rst_a",     sa_a_o,           32'd0);
    check("rst_b",     sa_b_o,           32'd0);
    check("rst_irq",   32'(irq_o),       32'd0);
    check("rst_ready", 32'(bus_ready_o), 32'd0);
    check("rst_rdata", bus_rdata_o,      32'd0);
    rst = 1'b0;
    rd_chk(8'h04, 32'd0, "rst_status");
    rd_chk(8'h08, 32'd0, "rst_cycles");
    rd_chk(8'h00, 32'd0, "rst_ctrl");
    rd_chk(8'hFC, 32'd0, "unmapped_rd");

    // identity
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        am[i][j] = (i == j) ? 1 : 0;
        bm[i][j] = 4*j + i + 1;
      end
    clr_before = clr_cnt;
    run("ident");
    check("ident_one_clear", 32'(clr_cnt - clr_before), 32'd1);
    rd_chk(8'h04, 32'h2, "ident_status");
    rd_chk(8'h20, 32'h04030201, "ident_bcol0");

    // signed
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        am[i][j] = -1;
        bm[i][j] = 2;
      end
    run("sgn");

    // protection: second START and A write while busy are ignored
    rand_mats();
    load_mats();
    row0_saved = row_word(0);
    clr_before = clr_cnt;
    wr(8'h00, 32'h1);
    rd_chk(8'h04, 32'h1, "prot_busy");
    wr(8'h00, 32'h1);
    wr(8'h10, ~row0_saved);
    wait_done("prot");
    check("prot_one_clear", 32'(clr_cnt - clr_before), 32'd1);
    rd_chk(8'h10, row0_saved, "prot_arow0");
    check_results("prot");

    // interrupt enabled, then DONE_CLR, then disabled
    rand_mats();
    load_mats();
    timed_run(1'b1, "irq1");
    check_results("irq1");
    wr(8'h00, 32'h6);
    @(posedge clk); #1;
    check("doneclr_irq", 32'(irq_o), 32'd0);
    rd_chk(8'h04, 32'h0, "doneclr_status");
    rd_chk(8'h00, 32'h2, "ctrl_irqen");
    timed_run(1'b0, "irq0");
    rd_chk(8'h04, 32'h2, "irq0_status");

    // reset in the middle of FEED at t=3
    rand_mats();
    load_mats();
    wr(8'h00, 32'h3);
    repeat (4) @(posedge clk);
    #1;
    check("midrst_en_before", 32'(sa_en_o), 32'd1);
    check("midrst_a_t3", sa_a_o, lanes_a(3));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_en",  32'(sa_en_o),  32'd0);
    check("midrst_clr", 32'(sa_clr_o), 32'd0);
    check("midrst_a",   sa_a_o,        32'd0);
    check("midrst_irq", 32'(irq_o),    32'd0);
    rd_chk(8'h04, 32'd0, "midrst_status");
    rd_chk(8'h08, 32'd0, "midrst_cycles");
    rd_chk(8'h00, 32'd0, "midrst_ctrl");
    rd_chk(8'h10, 32'd0, "midrst_arow0");
    rd_chk(8'h2C, 32'd0, "midrst_bcol3");
    rand_mats();
    run("fresh");

    for (int r = 0; r < 2; r++) begin
      rand_mats();
      run($sformatf("rnd%0d", r));
    end

    repeat (4) @(posedge clk);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Memory-mapped sequencer that sits between the RISC-V core's peripheral bus and the output-stationary N×N systolic matrix-multiply array.
- Firmware writes matrix A (row-packed) and B (column-packed) into local operand registers, then writes START.
- The block clears the array accumulators, feeds skewed operands into the array edges, and flushes the array pipeline.
- On completion it flags DONE and optionally raises `irq_o`.
- Results C = A·B are read back through the same bus window, straight from the array's accumulator outputs.

## Interface
Parameters:
- `N`, 4, array dimension; constraint N*DATA_W ≤ 32.
- `DATA_W`, 8, operand width (signed two's complement).
- `ACC_W`, 32, accumulator/result width.
- `SA_LAT`, 1, array pipeline flush cycles after the last operand.

Ports:
- `clk_i`  in  1  single system clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `bus_sel_i`  in  1  bus access request.
- `bus_we_i`  in  1  1 = write, 0 = read.
- `bus_addr_i`  in  8  byte address, word aligned.
- `bus_wdata_i`  in  32  write data.
- `bus_rdata_o`  out  32  read data, valid with `bus_ready_o`.
- `bus_ready_o`  out  1  access complete pulse.
- `sa_clr_o`  out  1  clear all array accumulators.
- `sa_en_o`  out  1  array shift/MAC enable.
- `sa_a_o`  out  N*DATA_W  left-edge inputs, lane i → row i.
- `sa_b_o`  out  N*DATA_W  top-edge inputs, lane j → column j.
- `sa_c_i`  in  N*N*ACC_W  accumulators, C[i][j] at index i*N+j.
- `irq_o`  out  1  level interrupt, done AND irq_en.

## Operation
Address map; unmapped reads return 0 and unmapped writes are ignored:
- 0x00 CTRL: bit0 START (write-1, self-clearing); bit1 IRQ_EN (R/W); bit2 DONE_CLR (write-1).
- 0x04 STATUS (RO): bit0 BUSY; bit1 DONE (sticky).
- 0x08 CYCLES (RO): cycles from START accept to DONE of the last run.
- 0x10+4i: A row i, element k at bits [k*DATA_W +: DATA_W].
- 0x20+4j: B column j, element k at bits [k*DATA_W +: DATA_W].
- 0x40+4(i*N+j): C[i][j], read-only, from `sa_c_i`.

FSM states and transitions:
- IDLE: START write → CLEAR. Clear DONE and CYCLES.
- CLEAR (1 cycle): `sa_clr_o`=1, `sa_en_o`=0. Go to FEED with step t=0.
- FEED (3N-2 cycles, t = 0..3N-3): `sa_en_o`=1.
  - A lane i = A[i][t-i] if 0 ≤ t-i < N, else 0.
  - B lane j = B[t-j][j] if 0 ≤ t-j < N, else 0.
- DRAIN (SA_LAT cycles): `sa_en_o`=1, zero operands.
- DONE (1 cycle): set DONE, latch CYCLES, go to IDLE.

BUSY is 1 in every state except IDLE.

Rules:
- START while BUSY: ignored.
- A/B writes while BUSY: ignored; operands stay stable for the whole run.
- C reads while BUSY: return live `sa_c_i`, which is not meaningful mid-run.
- DONE_CLR and START in the same write: START wins; DONE is cleared anyway.
- `rst_i` mid-run: next cycle is IDLE. All outputs 0, A/B/CTRL/STATUS/CYCLES cleared. The array is not cleared by the reset itself; it is cleared on the next run's CLEAR.

## Timing
- Reset values: all outputs 0.
- Bus:
  - Access is accepted on a cycle with `bus_sel_i`=1 and `bus_ready_o`=0.
  - `bus_ready_o` pulses 1 cycle later, with registered `bus_rdata_o`.
  - Back-to-back accesses are therefore spaced by at least 2 cycles.
  - Write side effects (START, register updates) take effect at the accept edge.
- Run latency: START accepted at edge 0.
  - CLEAR occupies cycle 1.
  - FEED occupies cycles 2..3N-1.
  - DRAIN follows for SA_LAT cycles.
  - DONE occupies cycle 3N+SA_LAT.
  - BUSY falls and DONE rises at the next edge.
- CYCLES = 3N+SA_LAT; this is 13 for N=4, SA_LAT=1.
- `irq_o` is registered. It follows DONE&IRQ_EN one cycle later.

## Structure
- Shared package `matmul_pkg`: address offsets, CTRL/STATUS bit positions, FSM state enum.
- Sub-module `matmul_skew_feeder`:
  - Purely combinational.
  - Inputs: operand registers and step t.
  - Outputs: `sa_a_o` and `sa_b_o` lane values, with zero outside the skew window.
- The top level holds the bus registers, FSM, counters and interrupt.

## Test plan
Benches use a behavioural N=4 output-stationary array model and N=4, SA_LAT=1.
- Reset: assert `rst_i` for 3 cycles → all outputs 0; STATUS and CYCLES read 0.
- Identity multiply: A = I (rows 0x00000001, 0x00000100, 0x00010000, 0x01000000), B columns 0x04030201… → after DONE, C equals B element-wise; CYCLES = 13.
- Signed: all A = 0xFF (-1), all B = 0x02 → every C[i][j] = 0xFFFFFFF8 (-8).
- Protection: write START while BUSY, and write A row 0 while BUSY → a single run only; the result uses the original A.
- IRQ: IRQ_EN=1 → `irq_o` rises 1 cycle after DONE. DONE_CLR drops it. A run with IRQ_EN=0 → `irq_o` stays 0.
- Reset mid-FEED (t=3) → next cycle BUSY=0, `sa_en_o`=0, all registers 0. A fresh run then gives correct results.
